ex_pipe: RTL and testbench
==========================

EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 SHALL have parameter LANES, default 2, number of independent execution lanes (1..8).
REQ-002 SHALL have parameter XLEN, default 32, operand/result width.
REQ-003 SHALL have ports `clk` (input, 1, rising-edge clock) and `reset` (input, 1, asynchronous active-high reset).
REQ-004 SHALL have port `flush` (input, 1): squash all in-flight work.
REQ-005 SHALL have port `is_tag_flooded` (input, 1): force result tag MSB.
REQ-006 SHALL have port `ex_contents[LANES]` (input, ex_content_t): per-lane issued operation with is_valid.
REQ-007 SHALL have port `in_ready[LANES]` (output, 1): lane accepts a new operation this cycle.
REQ-008 SHALL have port `load_data[LANES]` (input, XLEN): memory read data, same cycle as issue.
REQ-009 SHALL have ports `load_mode[LANES]` (output, ldst_mode_t) and `load_addr[LANES]` (output, XLEN): combinational from ex_contents rm/A.
REQ-010 SHALL have port `results[LANES]` (output, ex_result_t): registered per-lane result.
REQ-011 SHALL have ports `is_branch_established` (output, 1) and `jumped_to` (output, XLEN): registered redirect.

Function
REQ-012 SHALL accept lane i operation when ex_contents[i].is_valid & in_ready[i] & !flush.
REQ-013 SHALL produce ALU, BRANCH, MUL and LOAD results in results[i] exactly 1 cycle after acceptance.
REQ-014 SHALL select result by Unit: ALU→alu, BRANCH→pc+4, MUL→low XLEN product, LOAD→load_data, DIV→quotient/remainder per Op, other→0.
REQ-015 SHALL execute DIV per lane via div_iter: IDLE→RUN (XLEN cycles, one quotient bit/cycle)→DONE (sign fix-up)→IDLE; result valid XLEN+2 cycles after acceptance.
REQ-016 SHALL hold in_ready[i] low from the cycle after DIV acceptance through the DONE cycle; high otherwise.
REQ-017 SHALL return, on divide by zero, quotient all-ones and remainder = dividend.
REQ-018 SHALL return, on signed MIN/−1, quotient MIN and remainder 0.
REQ-019 SHALL set results[i].is_branch_established = Unit==BRANCH & mode==EX_NORMAL & condition true.
REQ-020 SHALL drive is_branch_established/jumped_to from the highest-index lane with an established branch; jumped_to=0 when none.
REQ-021 SHALL, when is_tag_flooded is high at capture, register tag as {1'b1, tag[BUF_SIZE_LOG-1:0]}; else tag unchanged.
REQ-022 SHALL pass mode and speculative_tag through with the result; jumped_to = operand A.
REQ-023 SHALL, on flush, clear all results[].is_valid and is_branch_established next cycle and return every div_iter to IDLE.
REQ-024 SHALL give flush priority over a DIV completing in the same cycle: no result emitted.
REQ-025 SHALL drive results[i].is_valid low in every cycle with no completing operation.

Reset
REQ-026 SHALL, on reset, clear all results fields, is_branch_established and jumped_to to 0, return div_iter to IDLE, and drive in_ready high after deassertion.
REQ-027 SHALL abandon any DIV in progress when reset asserts mid-operation; no result after deassertion.

Configuration
REQ-028 SHALL, with EX_DIV_ITER_EN defined, use the iterative divider of REQ-015/016.
REQ-029 SHALL, without EX_DIV_ITER_EN, compute DIV combinationally with 1-cycle latency and in_ready permanently high outside reset.

Structure
REQ-030 SHALL take ex_content_t, ex_result_t, unit_t, ex_mode_t, ldst_mode_t, tag_t, spectag_t, BUF_SIZE_LOG from the shared core package; ex_result_t moves there.
REQ-031 SHALL implement the divider as sub-module div_iter (one instance per lane), reusing existing alu/mul/branch units.

Verification
REQ-032 SHALL verify lane 0 DIV 100/7 (EX_DIV_ITER_EN) → quotient 14 valid at t+34, in_ready[0] low t+1..t+33, lane 1 ALU ops unaffected.
REQ-033 SHALL verify DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
REQ-034 SHALL verify established branches on both lanes, targets 0x100/0x200 → jumped_to 0x200 next cycle.
REQ-035 SHALL verify flush 10 cycles into a DIV → no result ever, in_ready high next cycle.
REQ-036 SHALL verify tag 0x05 with is_tag_flooded, BUF_SIZE_LOG=4 → result tag 0x15.

Source files
------------

// File: rtl/ex_pipe_pkg.sv
// Shared core types for the execution pipe: issue/result records, unit and
// mode encodings, and the combinational ALU / branch / divide helpers.
package ex_pipe_pkg;

    localparam int CORE_XLEN    = 32;
    localparam int BUF_SIZE_LOG = 4;
    localparam int SPECTAG_LEN  = 4;
    localparam int SHW          = $clog2(CORE_XLEN);

    typedef logic [BUF_SIZE_LOG:0]  tag_t;
    typedef logic [SPECTAG_LEN-1:0] spectag_t;

    typedef enum logic [2:0] {
        UNIT_ALU, UNIT_BRANCH, UNIT_MUL, UNIT_LOAD, UNIT_DIV, UNIT_STORE
    } unit_t;

    typedef enum logic [1:0] {EX_NORMAL, EX_EXCEPTION, EX_INTERRUPT} ex_mode_t;
    typedef enum logic [1:0] {LDST_BYTE, LDST_HALF, LDST_WORD} ldst_mode_t;

    // Op field is interpreted per unit
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9;
    localparam logic [3:0] BR_EQ = 4'd0, BR_NE = 4'd1, BR_LT = 4'd2, BR_GE = 4'd3,
                           BR_LTU = 4'd4, BR_GEU = 4'd5;
    localparam logic [3:0] DIV_DIV = 4'd0, DIV_DIVU = 4'd1, DIV_REM = 4'd2, DIV_REMU = 4'd3;

    localparam logic [1:0] DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_DONE = 2'd2;

    typedef struct packed {
        logic                  is_valid;
        unit_t                 unit;
        logic [3:0]            op;
        ex_mode_t              mode;
        ldst_mode_t            rm;
        logic [CORE_XLEN-1:0]  a;
        logic [CORE_XLEN-1:0]  b;
        logic [CORE_XLEN-1:0]  c;
        logic [CORE_XLEN-1:0]  pc;
        tag_t                  tag;
        spectag_t              speculative_tag;
    } ex_content_t;

    typedef struct packed {
        logic                  is_valid;
        logic [CORE_XLEN-1:0]  value;
        tag_t                  tag;
        spectag_t              speculative_tag;
        ex_mode_t              mode;
        logic                  is_branch_established;
        logic [CORE_XLEN-1:0]  jumped_to;
    } ex_result_t;

    function automatic logic [CORE_XLEN-1:0] alu_f(input logic [3:0] op,
                                                   input logic [CORE_XLEN-1:0] a,
                                                   input logic [CORE_XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_SLT:  return {{(CORE_XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: return {{(CORE_XLEN-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

    function automatic logic br_taken(input logic [3:0] op,
                                      input logic [CORE_XLEN-1:0] a,
                                      input logic [CORE_XLEN-1:0] b);
        case (op)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Single-cycle divide used when the iterative divider is not built
    function automatic logic [CORE_XLEN-1:0] div_comb(input logic [3:0] op,
                                                      input logic [CORE_XLEN-1:0] a,
                                                      input logic [CORE_XLEN-1:0] b);
        logic sgn, rem;
        sgn = (op == DIV_DIV) || (op == DIV_REM);
        rem = (op == DIV_REM) || (op == DIV_REMU);
        if (b == '0)
            return rem ? a : '1;
        if (sgn && (a == {1'b1, {(CORE_XLEN-1){1'b0}}}) && (b == '1))
            return rem ? '0 : a;
        if (sgn)
            return rem ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    // Wrap a computed value with the bookkeeping fields of its issue record
    function automatic ex_result_t pack_result(input ex_content_t c,
                                               input logic [CORE_XLEN-1:0] value,
                                               input logic flooded);
        ex_result_t r;
        r                       = '0;
        r.is_valid              = 1'b1;
        r.value                 = value;
        r.tag                   = flooded ? {1'b1, c.tag[BUF_SIZE_LOG-1:0]} : c.tag;
        r.speculative_tag       = c.speculative_tag;
        r.mode                  = c.mode;
        r.is_branch_established = (c.unit == UNIT_BRANCH) && (c.mode == EX_NORMAL)
                                  && br_taken(c.op, c.b, c.c);
        r.jumped_to             = c.a;
        return r;
    endfunction

endpackage

// File: rtl/ex_pipe_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, with sign fix-up
// and divide-by-zero handling applied in the final state.
//
// state    | meaning
// DIV_IDLE | waiting for start
// DIV_RUN  | XLEN shift/subtract iterations on operand magnitudes
// DIV_DONE | quotient/remainder valid (signs restored) for one cycle
module div_iter
    import ex_pipe_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo, r_dvsr, r_dvnd;
    logic [XLEN:0]   r_rem;
    logic            r_q_neg, r_r_neg, r_by_zero;
    logic [XLEN:0]   w_rem_shift, w_rem_sub;
    logic [XLEN-1:0] w_abs_a, w_abs_b;

    assign w_abs_a     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    assign w_abs_b     = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
    assign w_rem_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_dvsr};

    // Sequencer and shift/subtract datapath; flush abandons any operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_dvnd    <= '0;
            r_rem     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_by_zero <= 1'b0;
        end else if (flush) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: if (start) begin
                    r_state   <= DIV_RUN;
                    r_cnt     <= CW'(XLEN);
                    r_quo     <= w_abs_a;
                    r_dvsr    <= w_abs_b;
                    r_dvnd    <= dividend;
                    r_rem     <= '0;
                    r_by_zero <= (divisor == '0);
                    r_q_neg   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                    r_r_neg   <= is_signed && dividend[XLEN-1];
                end
                DIV_RUN: begin
                    r_rem <= w_rem_sub[XLEN] ? w_rem_shift : w_rem_sub;
                    r_quo <= {r_quo[XLEN-2:0], ~w_rem_sub[XLEN]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= DIV_DONE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != DIV_IDLE);
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_by_zero ? '1 : (r_q_neg ? -r_quo : r_quo);
    assign remainder = r_by_zero ? r_dvnd
                     : (r_r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0]);

endmodule

// File: rtl/ex_pipe.sv
// Multi-lane execution stage: ALU / branch / MUL / LOAD results one cycle
// after issue, DIV either single-cycle or through a per-lane iterative
// divider. Define EX_DIV_ITER_EN to build the iterative divider.
module ex_pipe
    import ex_pipe_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = CORE_XLEN
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            is_tag_flooded,
    input  ex_content_t     ex_contents [LANES],
    output logic            in_ready    [LANES],
    input  logic [XLEN-1:0] load_data   [LANES],
    output ldst_mode_t      load_mode   [LANES],
    output logic [XLEN-1:0] load_addr   [LANES],
    output ex_result_t      results     [LANES],
    output logic            is_branch_established,
    output logic [XLEN-1:0] jumped_to
);
    ex_result_t      w_next    [LANES];
    ex_result_t      r_results [LANES];
    logic            w_br, r_br;
    logic [XLEN-1:0] w_target, r_target;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic            w_accept;
        logic [XLEN-1:0] w_value;

        assign load_mode[i] = ex_contents[i].rm;
        assign load_addr[i] = ex_contents[i].a;
        assign w_accept     = ex_contents[i].is_valid & in_ready[i] & ~flush;
        assign results[i]   = r_results[i];

        // Single-cycle value by functional unit
        always_comb begin
            w_value = '0;
            case (ex_contents[i].unit)
                UNIT_ALU:    w_value = alu_f(ex_contents[i].op, ex_contents[i].a, ex_contents[i].b);
                UNIT_BRANCH: w_value = ex_contents[i].pc + XLEN'(4);
                UNIT_MUL:    w_value = ex_contents[i].a * ex_contents[i].b;
                UNIT_LOAD:   w_value = load_data[i];
`ifndef EX_DIV_ITER_EN
                UNIT_DIV:    w_value = div_comb(ex_contents[i].op, ex_contents[i].a, ex_contents[i].b);
`endif
                default:     w_value = '0;
            endcase
        end

`ifdef EX_DIV_ITER_EN
        logic            w_div_start, w_div_busy, w_div_done, w_div_signed, w_div_is_rem;
        logic [XLEN-1:0] w_quo, w_rem;
        logic [3:0]      r_div_op;
        tag_t            r_div_tag;
        spectag_t        r_div_spec;
        ex_mode_t        r_div_mode;
        logic [XLEN-1:0] r_div_a;
        ex_content_t     w_div_ctx;

        assign w_div_start  = w_accept & (ex_contents[i].unit == UNIT_DIV);
        assign w_div_signed = (ex_contents[i].op == DIV_DIV) | (ex_contents[i].op == DIV_REM);
        assign w_div_is_rem = (r_div_op == DIV_REM) | (r_div_op == DIV_REMU);

        div_iter #(.XLEN(XLEN)) u_div (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .start     (w_div_start),
            .is_signed (w_div_signed),
            .dividend  (ex_contents[i].a),
            .divisor   (ex_contents[i].b),
            .busy      (w_div_busy),
            .done      (w_div_done),
            .quotient  (w_quo),
            .remainder (w_rem)
        );

        // Hold the DIV's bookkeeping fields until its value is ready
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_div_op   <= '0;
                r_div_tag  <= '0;
                r_div_spec <= '0;
                r_div_mode <= EX_NORMAL;
                r_div_a    <= '0;
            end else if (w_div_start) begin
                r_div_op   <= ex_contents[i].op;
                r_div_tag  <= ex_contents[i].tag;
                r_div_spec <= ex_contents[i].speculative_tag;
                r_div_mode <= ex_contents[i].mode;
                r_div_a    <= ex_contents[i].a;
            end
        end

        // Rebuild an issue record for the completing DIV so it packs like any op
        always_comb begin
            w_div_ctx                 = '0;
            w_div_ctx.unit            = UNIT_DIV;
            w_div_ctx.op              = r_div_op;
            w_div_ctx.tag             = r_div_tag;
            w_div_ctx.speculative_tag = r_div_spec;
            w_div_ctx.mode            = r_div_mode;
            w_div_ctx.a               = r_div_a;
        end

        assign in_ready[i] = ~w_div_busy;
        assign w_next[i]   = (w_accept && (ex_contents[i].unit != UNIT_DIV))
                             ? pack_result(ex_contents[i], w_value, is_tag_flooded)
                           : w_div_done
                             ? pack_result(w_div_ctx, w_div_is_rem ? w_rem : w_quo, is_tag_flooded)
                           : ex_result_t'('0);
`else
        assign in_ready[i] = 1'b1;
        assign w_next[i]   = w_accept ? pack_result(ex_contents[i], w_value, is_tag_flooded)
                                      : ex_result_t'('0);
`endif
    end

    // Redirect comes from the highest-index lane with an established branch
    always_comb begin
        w_br     = 1'b0;
        w_target = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_next[i].is_branch_established) begin
                w_br     = 1'b1;
                w_target = w_next[i].jumped_to;
            end
        end
    end

    // Result and redirect registers; flush squashes everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) r_results[i] <= '0;
            r_br     <= 1'b0;
            r_target <= '0;
        end else if (flush) begin
            for (int i = 0; i < LANES; i++) r_results[i] <= '0;
            r_br     <= 1'b0;
            r_target <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) r_results[i] <= w_next[i];
            r_br     <= w_br;
            r_target <= w_target;
        end
    end

    assign is_branch_established = r_br;
    assign jumped_to             = r_target;

endmodule

// File: tb/tb_ex_pipe.sv
// Directed bench for ex_pipe (LANES=2, XLEN=32). Divide expectations follow
// the build: EX_DIV_ITER_EN selects the multi-cycle timing.
module tb_ex_pipe;
    import ex_pipe_pkg::*;

`ifdef EX_DIV_ITER_EN
    localparam int DIV_LAT = 34;
`else
    localparam int DIV_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, is_tag_flooded;
    ex_content_t ex_contents [2];
    logic        in_ready    [2];
    logic [31:0] load_data   [2];
    ldst_mode_t  load_mode   [2];
    logic [31:0] load_addr   [2];
    ex_result_t  results     [2];
    logic        is_branch_established;
    logic [31:0] jumped_to;

    int n_checks = 0;
    int n_errors = 0;

    ex_pipe #(.LANES(2), .XLEN(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .flush                 (flush),
        .is_tag_flooded        (is_tag_flooded),
        .ex_contents           (ex_contents),
        .in_ready              (in_ready),
        .load_data             (load_data),
        .load_mode             (load_mode),
        .load_addr             (load_addr),
        .results               (results),
        .is_branch_established (is_branch_established),
        .jumped_to             (jumped_to)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ex_content_t mk(input unit_t u, input logic [3:0] op,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] pc,
                                       input tag_t tg);
        ex_content_t e;
        e          = '0;
        e.is_valid = 1'b1;
        e.unit     = u;
        e.op       = op;
        e.mode     = EX_NORMAL;
        e.a        = a;
        e.b        = b;
        e.c        = c;
        e.pc       = pc;
        e.tag      = tg;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ex_contents[0] = '0;
        ex_contents[1] = '0;
    endtask

    // Issue a DIV-unit op on lane 0 and wait (bounded) for its result
    task automatic run_div(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int          lat;
        bit          got;
        logic [31:0] val;
        lat = 0;
        got = 0;
        val = '0;
        @(negedge clk);
        ex_contents[0] = mk(UNIT_DIV, op, a, b, 32'd0, 32'd0, 5'h02);
        for (int k = 1; k <= 60 && !got; k++) begin
            step();
            if (results[0].is_valid) begin
                got = 1;
                lat = k;
                val = results[0].value;
            end
            @(negedge clk);
            ex_contents[0] = '0;
        end
        check({tag, " latency"}, lat, DIV_LAT);
        check({tag, " value"}, val, exp);
    endtask

    initial begin
        ex_content_t e;
        bit          seen;
        reset = 1'b1;
        flush = 1'b0;
        is_tag_flooded = 1'b0;
        idle_all();
        load_data[0] = '0;
        load_data[1] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst valid0", results[0].is_valid, 0);
        check("rst value1", results[1].value, 0);
        check("rst br", is_branch_established, 0);
        check("rst jumped_to", jumped_to, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst ready0", in_ready[0], 1);
        check("rst ready1", in_ready[1], 1);

        // ALU ops on both lanes
        @(negedge clk);
        ex_contents[0] = mk(UNIT_ALU, OP_ADD, 32'd3, 32'd4, 0, 0, 5'h01);
        ex_contents[1] = mk(UNIT_ALU, OP_XOR, 32'hF0, 32'h0F, 0, 0, 5'h03);
        step();
        check("add valid", results[0].is_valid, 1);
        check("add value", results[0].value, 32'd7);
        check("add tag", results[0].tag, 5'h01);
        check("xor value", results[1].value, 32'hFF);
        @(negedge clk);
        ex_contents[0] = mk(UNIT_ALU, OP_SRA, 32'h8000_0000, 32'd4, 0, 0, 5'h00);
        ex_contents[1] = mk(UNIT_ALU, OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'h00);
        step();
        check("sra value", results[0].value, 32'hF800_0000);
        check("slt value", results[1].value, 32'd1);
        @(negedge clk);
        idle_all();
        step();
        check("idle valid0", results[0].is_valid, 0);
        check("idle valid1", results[1].is_valid, 0);

        // MUL low word and LOAD passthrough, with combinational load address
        @(negedge clk);
        ex_contents[0] = mk(UNIT_MUL, 4'd0, 32'h0001_0000, 32'h0001_0003, 0, 0, 5'h00);
        e = mk(UNIT_LOAD, 4'd0, 32'h0000_1234, 0, 0, 0, 5'h07);
        e.rm = LDST_HALF;
        ex_contents[1] = e;
        load_data[1] = 32'hDEAD_BEEF;
        #1;
        check("load_addr", load_addr[1], 32'h1234);
        check("load_mode", load_mode[1], LDST_HALF);
        step();
        check("mul value", results[0].value, 32'h0003_0000);
        check("load value", results[1].value, 32'hDEAD_BEEF);
        check("load tag", results[1].tag, 5'h07);

        // Branches established on both lanes: highest lane wins
        @(negedge clk);
        ex_contents[0] = mk(UNIT_BRANCH, BR_EQ, 32'h100, 32'd9, 32'd9, 32'h40, 5'h00);
        ex_contents[1] = mk(UNIT_BRANCH, BR_LT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h80, 5'h00);
        step();
        check("br2 established", is_branch_established, 1);
        check("br2 jumped_to", jumped_to, 32'h200);
        check("br2 link0", results[0].value, 32'h44);
        check("br2 lane0 est", results[0].is_branch_established, 1);
        check("br2 link1", results[1].value, 32'h84);
        // Only lane 0 taken
        @(negedge clk);
        ex_contents[0] = mk(UNIT_BRANCH, BR_GEU, 32'h100, 32'd5, 32'd3, 32'h40, 5'h00);
        ex_contents[1] = mk(UNIT_BRANCH, BR_NE, 32'h200, 32'd7, 32'd7, 32'h80, 5'h00);
        step();
        check("br0 established", is_branch_established, 1);
        check("br0 jumped_to", jumped_to, 32'h100);
        check("br0 lane1 est", results[1].is_branch_established, 0);
        // None taken, and a non-normal-mode branch never establishes
        @(negedge clk);
        ex_contents[0] = mk(UNIT_BRANCH, BR_LTU, 32'h100, 32'd5, 32'd3, 32'h40, 5'h00);
        e = mk(UNIT_BRANCH, BR_EQ, 32'h200, 32'd1, 32'd1, 32'h80, 5'h00);
        e.mode = EX_EXCEPTION;
        ex_contents[1] = e;
        step();
        check("brn established", is_branch_established, 0);
        check("brn jumped_to", jumped_to, 0);
        check("brn mode1", results[1].mode, EX_EXCEPTION);
        check("brn lane1 est", results[1].is_branch_established, 0);

        // Tag flooding
        @(negedge clk);
        is_tag_flooded = 1'b1;
        ex_contents[0] = mk(UNIT_ALU, OP_ADD, 1, 1, 0, 0, 5'h05);
        e = mk(UNIT_ALU, OP_ADD, 1, 1, 0, 0, 5'h1A);
        e.speculative_tag = 4'h9;
        ex_contents[1] = e;
        step();
        check("flood tag0", results[0].tag, 5'h15);
        check("flood tag1", results[1].tag, 5'h1A);
        check("spectag pass", results[1].speculative_tag, 4'h9);
        @(negedge clk);
        is_tag_flooded = 1'b0;
        ex_contents[0] = mk(UNIT_ALU, OP_ADD, 1, 1, 0, 0, 5'h05);
        step();
        check("noflood tag0", results[0].tag, 5'h05);

        // Flush blocks acceptance
        @(negedge clk);
        flush = 1'b1;
        ex_contents[0] = mk(UNIT_ALU, OP_ADD, 2, 2, 0, 0, 5'h00);
        ex_contents[1] = mk(UNIT_BRANCH, BR_EQ, 32'h300, 0, 0, 0, 5'h00);
        step();
        check("flush valid0", results[0].is_valid, 0);
        check("flush br", is_branch_established, 0);
        @(negedge clk);
        flush = 1'b0;
        idle_all();

        // DIV 100/7 on lane 0 while lane 1 keeps issuing ALU adds
        @(negedge clk);
        ex_contents[0] = mk(UNIT_DIV, DIV_DIV, 32'd100, 32'd7, 0, 0, 5'h00);
        ex_contents[1] = mk(UNIT_ALU, OP_ADD, 32'd0, 32'd100, 0, 0, 5'h00);
        for (int k = 1; k <= 36; k++) begin
            step();
            check($sformatf("lane1 add k%0d", k), results[1].value, 32'(k - 1 + 100));
            check($sformatf("ready0 k%0d", k), in_ready[0], (DIV_LAT == 1) ? 1'b1 : (k >= 34));
            check($sformatf("div valid k%0d", k), results[0].is_valid, k == DIV_LAT);
            if (k == DIV_LAT) check("div 100/7", results[0].value, 32'd14);
            @(negedge clk);
            ex_contents[0] = '0;
            ex_contents[1] = mk(UNIT_ALU, OP_ADD, 32'(k), 32'd100, 0, 0, 5'h00);
        end
        idle_all();

        // Divide corner cases
        run_div("div 5/0", DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_div("rem 5/0", DIV_REM, 32'd5, 32'd0, 32'd5);
        run_div("div min/-1", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem min/-1", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("div -100/7", DIV_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_div("rem -100/7", DIV_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        run_div("divu", DIV_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        run_div("remu", DIV_REMU, 32'd100, 32'd7, 32'd2);

`ifdef EX_DIV_ITER_EN
        // Flush ten cycles into a DIV
        @(negedge clk);
        ex_contents[0] = mk(UNIT_DIV, DIV_DIV, 32'd100, 32'd7, 0, 0, 5'h00);
        for (int k = 1; k <= 9; k++) begin
            step();
            @(negedge clk);
            ex_contents[0] = '0;
        end
        step();
        check("preflush busy", in_ready[0], 0);
        @(negedge clk);
        flush = 1'b1;
        step();
        check("postflush ready", in_ready[0], 1);
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (results[0].is_valid) seen = 1;
        end
        check("flushed div silent", seen, 0);

        // Flush in the completing cycle wins
        @(negedge clk);
        ex_contents[0] = mk(UNIT_DIV, DIV_DIV, 32'd100, 32'd7, 0, 0, 5'h00);
        for (int k = 1; k <= 33; k++) begin
            step();
            @(negedge clk);
            ex_contents[0] = '0;
        end
        flush = 1'b1;
        step();
        check("done flush valid", results[0].is_valid, 0);
        check("done flush ready", in_ready[0], 1);
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (results[0].is_valid) seen = 1;
        end
        check("done flush silent", seen, 0);

        // Reset mid-DIV abandons it
        @(negedge clk);
        ex_contents[0] = mk(UNIT_DIV, DIV_DIV, 32'd100, 32'd7, 0, 0, 5'h00);
        step();
        @(negedge clk);
        ex_contents[0] = '0;
        repeat (4) step();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst mid ready", in_ready[0], 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (results[0].is_valid) seen = 1;
        end
        check("rst mid silent", seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
